// File: rtl/fft_input_loader.sv
// -----------------------------------------------------------------------------
// fft_input_loader
//
// Front end of the FFT sample memory. Accepts a valid/ready stream of complex
// samples and writes one frame of FFT_POINTS samples into the write port of
// the dual-port sample memory. Once a full frame is resident, frame_ready is
// raised and the source is held off until the FFT core pulses frame_ack.
//
// Build option:
//   FFT_LOADER_BITREV_EN  defined   -> write address is the bit reversal of
//                                      the sample count, so the butterfly
//                                      engine can read in natural order
//                         undefined -> write address equals the sample count
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       sample stream handshake (s_ready is registered)
//   s_real, s_imag        sample payload
//   s_last                source's end-of-frame marker
//   mem_we, mem_addr      memory write strobe and address
//   mem_real, mem_imag    memory write data
//   frame_ready           level: a complete frame sits in memory
//   frame_ack             1-cycle pulse from the core: frame consumed
//   len_err               1-cycle pulse: s_last disagreed with sample count
//   frame_cnt             completed frames, wraps 255 -> 0
//
// Every output is a flop, so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module fft_input_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_POINTS = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_imag,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_real,
  output logic [DATA_WIDTH-1:0] mem_imag,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic                  len_err,
  output logic [7:0]            frame_cnt
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(FFT_POINTS - 1);

  // Maps the in-frame sample index to its memory location.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] cnt);
    logic [ADDR_WIDTH-1:0] v_addr;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      v_addr[b] = cnt[ADDR_WIDTH-1-b];
    end
`else
    v_addr = cnt;
`endif
    return v_addr;
  endfunction

  // Registered state and outputs
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_s_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_real;
  logic [DATA_WIDTH-1:0] r_mem_imag;
  logic                  r_frame_ready;
  logic                  r_len_err;
  logic [7:0]            r_frame_cnt;

  // Next-state values
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_count_next;
  logic                  w_hs;
  logic                  w_mem_we_next;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [DATA_WIDTH-1:0] w_mem_real_next;
  logic [DATA_WIDTH-1:0] w_mem_imag_next;
  logic                  w_len_err_next;
  logic [7:0]            w_frame_cnt_next;

  // The handshake uses the registered ready, which is only high in LOAD.
  assign w_hs = s_valid && r_s_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case statement so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_real_next  = r_mem_real;
    w_mem_imag_next  = r_mem_imag;
    w_len_err_next   = 1'b0;
    w_frame_cnt_next = r_frame_cnt;

    unique case (r_state)
      LOAD: begin
        if (w_hs) begin
          w_mem_we_next   = 1'b1;
          w_mem_addr_next = addr_of(r_count);
          w_mem_real_next = s_real;
          w_mem_imag_next = s_imag;
          if (r_count == LAST_CNT) begin
            // Frame complete regardless of s_last; a missing marker is
            // flagged but the frame is still handed to the core.
            w_state_next     = FULL;
            w_count_next     = '0;
            w_frame_cnt_next = r_frame_cnt + 8'd1;
            w_len_err_next   = !s_last;
          end else if (s_last) begin
            // Early marker: abandon the partial frame, restart at index 0.
            w_count_next   = '0;
            w_len_err_next = 1'b1;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
      end
      FULL: begin
        if (frame_ack) begin
          w_state_next = LOAD;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= LOAD;
      r_count       <= '0;
      r_s_ready     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_real    <= '0;
      r_mem_imag    <= '0;
      r_frame_ready <= 1'b0;
      r_len_err     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      // Ready and frame_ready follow the next state so they change on the
      // same edge that moves the FSM.
      r_s_ready     <= (w_state_next == LOAD);
      r_frame_ready <= (w_state_next == FULL);
      r_mem_we      <= w_mem_we_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_real    <= w_mem_real_next;
      r_mem_imag    <= w_mem_imag_next;
      r_len_err     <= w_len_err_next;
      r_frame_cnt   <= w_frame_cnt_next;
    end
  end

  assign s_ready     = r_s_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_real    = r_mem_real;
  assign mem_imag    = r_mem_imag;
  assign frame_ready = r_frame_ready;
  assign len_err     = r_len_err;
  assign frame_cnt   = r_frame_cnt;

endmodule
